mix_digest_sink: RTL and testbench

// Consumer-side counterpart of the 8-lane 32-bit mixing state generator. Accepts a frame of up to

---
 rtl/mix_digest_sink.sv | 170 +++++++++++++++++
 tb/tb_mix_digest_sink.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mix_digest_sink.sv
// mix_digest_sink
//
// Collects a frame of up to eight 32-bit words into lanes L0..L7, runs
// ROUNDS mixing rounds (one per clock), then offers the XOR of all lanes as
// a single 32-bit digest.
//
// Ports
//   clk, rst     rising-edge clock, synchronous active-high reset
//   in_valid     in_data / in_last are valid
//   in_ready     block accepts a word this cycle (only while loading)
//   in_data      frame word; the k-th accepted word loads lane Lk
//   in_last      marks the final word of a frame
//   out_valid    digest is available
//   out_ready    downstream takes the digest
//   out_digest   L0^L1^...^L7 after the final round
//   out_err      frame reached eight words without in_last on the eighth
//   dbg_state    current FSM state (LOAD=0, MIX=1, OUT=2) for observation
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. The producer holds valid and payload until that edge; ready may
// change freely and never depends on valid. While out_valid is high,
// out_digest and out_err do not change.
module mix_digest_sink #(
    parameter int unsigned ROUNDS = 4    // legal range 1..255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_digest,
    output logic        out_err,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_MIX  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    typedef logic [7:0][31:0] lanes_t;

    localparam logic [7:0] LAST_RND = 8'(ROUNDS - 1);

    // Lanes not written by a short frame keep the value Li = i.
    function automatic lanes_t pad_lanes();
        lanes_t l;
        for (int i = 0; i < 8; i++) begin
            l[3'(i)] = 32'(i);
        end
        return l;
    endfunction

    // One round: steps A, B, C. Within each step the lanes are updated in
    // index order, so lane i already sees the new values of lanes 0..i-1.
    function automatic lanes_t mix_round(input lanes_t l_in);
        lanes_t m;
        m = l_in;
        for (int i = 0; i < 8; i++) begin
            m[3'(i)] = m[3'(i)] + m[3'(i + 7)];
        end
        for (int i = 0; i < 8; i++) begin
            m[3'(i)] = m[3'(i)] ^ (m[3'(i + 3)] << 16);
        end
        for (int i = 0; i < 8; i++) begin
            m[3'(i)] = m[3'(i)] - (m[3'(i + 2)] >> 17) + (m[3'(i + 4)] >> 12);
        end
        return m;
    endfunction

    function automatic logic [31:0] fold_lanes(input lanes_t l);
        logic [31:0] d;
        d = '0;
        for (int i = 0; i < 8; i++) begin
            d = d ^ l[3'(i)];
        end
        return d;
    endfunction

    state_t      state, state_nx;
    lanes_t      lanes;
    lanes_t      mixed;
    logic [2:0]  cnt;
    logic [7:0]  rcnt;
    logic        err_r;
    logic        accept;
    logic        frame_end;

    assign mixed     = mix_round(lanes);
    assign accept    = in_valid && in_ready;
    // The eighth word closes the frame even without in_last.
    assign frame_end = in_last || (cnt == 3'd7);
    assign dbg_state = state;

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            S_LOAD: begin
                in_ready = 1'b1;
                if (in_valid && frame_end) begin
                    state_nx = S_MIX;
                end
            end
            S_MIX: begin
                if (rcnt == LAST_RND) begin
                    state_nx = S_OUT;
                end
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nx = S_LOAD;
                end
            end
            default: state_nx = S_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_LOAD;
            lanes      <= pad_lanes();
            cnt        <= 3'd0;
            rcnt       <= 8'd0;
            err_r      <= 1'b0;
            out_digest <= 32'd0;
            out_err    <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                S_LOAD: begin
                    if (accept) begin
                        lanes[cnt] <= in_data;
                        cnt        <= cnt + 3'd1;
                        if (frame_end) begin
                            cnt   <= 3'd0;
                            rcnt  <= 8'd0;
                            err_r <= (cnt == 3'd7) && !in_last;
                        end
                    end
                end
                S_MIX: begin
                    lanes <= mixed;
                    rcnt  <= rcnt + 8'd1;
                    // Capture the result on the last round so the outputs
                    // are registered and stay put through the whole OUT phase
                    // and after it, until the next frame's result.
                    if (rcnt == LAST_RND) begin
                        out_digest <= fold_lanes(mixed);
                        out_err    <= err_r;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        lanes <= pad_lanes();
                        cnt   <= 3'd0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mix_digest_sink.sv
// Testbench for mix_digest_sink. Two instances share clock and reset:
// index 0 runs with ROUNDS=1, index 1 with ROUNDS=4.
module tb_mix_digest_sink;

    localparam int R0 = 1;
    localparam int R1 = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic        in_valid   [2];
    logic        in_ready   [2];
    logic [31:0] in_data    [2];
    logic        in_last    [2];
    logic        out_valid  [2];
    logic        out_ready  [2];
    logic [31:0] out_digest [2];
    logic        out_err    [2];
    logic [1:0]  dbg_state  [2];

    mix_digest_sink #(.ROUNDS(R0)) dut_r1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
        .in_last(in_last[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_digest(out_digest[0]), .out_err(out_err[0]), .dbg_state(dbg_state[0])
    );

    mix_digest_sink #(.ROUNDS(R1)) dut_r4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
        .in_last(in_last[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_digest(out_digest[1]), .out_err(out_err[1]), .dbg_state(dbg_state[1])
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [32:0] exp_q[$];    // {err, digest}

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic int rounds_of(input int d);
        return (d == 0) ? R0 : R1;
    endfunction

    // Reference: straight from the round rules, lanes as a plain array.
    function automatic logic [31:0] model_digest(input logic [31:0] w[8], input int n,
                                                 input int rounds);
        logic [31:0] l[8];
        logic [31:0] d;
        for (int i = 0; i < 8; i++) l[i] = (i < n) ? w[i] : 32'(i);
        for (int r = 0; r < rounds; r++) begin
            for (int i = 0; i < 8; i++) l[i] = l[i] + l[(i + 7) % 8];
            for (int i = 0; i < 8; i++) l[i] = l[i] ^ (l[(i + 3) % 8] << 16);
            for (int i = 0; i < 8; i++)
                l[i] = l[i] - (l[(i + 2) % 8] >> 17) + (l[(i + 4) % 8] >> 12);
        end
        d = 32'd0;
        for (int i = 0; i < 8; i++) d = d ^ l[i];
        return d;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic send_frame(input int d, input logic [31:0] w[8], input int n,
                              input bit last_final, input bit gaps);
        int guard;
        for (int k = 0; k < n; k++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 3)) begin
                    @(negedge clk);
                    in_valid[d] = 1'b0;
                    in_data[d]  = w[k];
                    in_last[d]  = (k == n - 1) && last_final;
                end
            end
            @(negedge clk);
            in_valid[d] = 1'b1;
            in_data[d]  = w[k];
            in_last[d]  = (k == n - 1) && last_final;
            guard = 0;
            while (!in_ready[d] && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            if (guard == 50) check("in_ready_timeout", 32'(in_ready[d]), 32'd1);
            @(posedge clk);
        end
    endtask

    // Waits for the digest, compares it with the scoreboard head, optionally
    // stalls the output for hold cycles, then completes the handshake.
    task automatic collect(input int d, input int hold);
        int lat;
        bit seen;
        logic [32:0] exp;
        lat  = 0;
        seen = 1'b0;
        @(negedge clk);
        in_valid[d] = 1'b0;
        while (lat <= rounds_of(d) + 20) begin
            if (out_valid[d]) begin
                seen = 1'b1;
                break;
            end
            // Words offered while in_ready is low must be ignored.
            in_valid[d] = 1'($urandom_range(0, 1));
            in_data[d]  = $urandom;
            in_last[d]  = 1'($urandom_range(0, 1));
            @(negedge clk);
            lat++;
        end
        in_valid[d] = 1'b0;
        in_last[d]  = 1'b0;
        if (!seen) begin
            check("out_valid_timeout", 32'd0, 32'd1);
            void'(exp_q.pop_front());
            return;
        end
        exp = exp_q.pop_front();
        check("latency", 32'(lat), 32'(rounds_of(d)));
        check("in_ready_in_out", 32'(in_ready[d]), 32'd0);
        check("digest", out_digest[d], exp[31:0]);
        check("err", 32'(out_err[d]), 32'(exp[32]));
        for (int c = 0; c < hold; c++) begin
            @(negedge clk);
            check("hold_valid", 32'(out_valid[d]), 32'd1);
            check("hold_digest", out_digest[d], exp[31:0]);
        end
        out_ready[d] = 1'b1;
        @(negedge clk);
        out_ready[d] = 1'b0;
        check("valid_fall", 32'(out_valid[d]), 32'd0);
        check("ready_back", 32'(in_ready[d]), 32'd1);
        check("digest_after", out_digest[d], exp[31:0]);
        check("err_after", 32'(out_err[d]), 32'(exp[32]));
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int          n;
        bit          last_final;
        logic [31:0] w[8];
        logic [31:0] exp_digest;
        logic        exp_err;
    } vec_t;

    vec_t tbl[5];

    initial begin
        logic [31:0] w[8];
        int n;
        bit lf;
        bit stayed_low;

        for (int d = 0; d < 2; d++) begin
            in_valid[d] = 0; in_data[d] = 0; in_last[d] = 0; out_ready[d] = 0;
        end

        // ROUNDS=1 vectors: pad/short frames and full frames
        for (int i = 0; i < 8; i++) begin
            tbl[0].w[i] = 32'd0;
            tbl[1].w[i] = 32'(i);
            tbl[2].w[i] = 32'd0;
            tbl[3].w[i] = 32'(i);
            tbl[4].w[i] = 32'(i);
        end
        tbl[0].n = 1; tbl[0].last_final = 1; tbl[0].exp_digest = 32'h003003C4; tbl[0].exp_err = 0;
        tbl[1].n = 8; tbl[1].last_final = 1; tbl[1].exp_digest = 32'h003003C4; tbl[1].exp_err = 0;
        tbl[2].n = 8; tbl[2].last_final = 0; tbl[2].exp_digest = 32'h00000000; tbl[2].exp_err = 1;
        tbl[3].n = 8; tbl[3].last_final = 0; tbl[3].exp_digest = 32'h003003C4; tbl[3].exp_err = 1;
        tbl[4].n = 2; tbl[4].last_final = 1; tbl[4].exp_digest = 32'h003003C4; tbl[4].exp_err = 0;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            check("rst_in_ready", 32'(in_ready[d]), 32'd1);
            check("rst_out_valid", 32'(out_valid[d]), 32'd0);
            check("rst_digest", out_digest[d], 32'd0);
            check("rst_err", 32'(out_err[d]), 32'd0);
        end

        for (int t = 0; t < 5; t++) begin
            exp_q.push_back({tbl[t].exp_err, tbl[t].exp_digest});
            send_frame(0, tbl[t].w, tbl[t].n, tbl[t].last_final, 1'b0);
            collect(0, 0);
        end

        // Output stall for 10 cycles, ROUNDS=4
        for (int i = 0; i < 8; i++) w[i] = 32'd0;
        exp_q.push_back({1'b0, model_digest(w, 1, R1)});
        send_frame(1, w, 1, 1'b1, 1'b0);
        collect(1, 10);

        // Reset pulse in the middle of MIX discards the frame
        for (int i = 0; i < 8; i++) w[i] = $urandom;
        send_frame(1, w, 3, 1'b1, 1'b0);
        @(negedge clk);
        in_valid[1] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        stayed_low = 1'b1;
        repeat (R1 + 6) begin
            if (out_valid[1]) stayed_low = 1'b0;
            @(negedge clk);
        end
        check("no_valid_after_rst", 32'(stayed_low), 32'd1);
        check("rst_mid_ready", 32'(in_ready[1]), 32'd1);
        check("rst_mid_digest", out_digest[1], 32'd0);
        for (int i = 0; i < 8; i++) w[i] = 32'd0;
        exp_q.push_back({1'b0, model_digest(w, 1, R1)});
        send_frame(1, w, 1, 1'b1, 1'b0);
        collect(1, 0);

        // Random frames with random in_valid gaps on both instances
        for (int f = 0; f < 40; f++) begin
            int d;
            d  = f % 2;
            n  = $urandom_range(1, 8);
            lf = (n < 8) ? 1'b1 : 1'($urandom_range(0, 1));
            for (int i = 0; i < 8; i++) w[i] = $urandom;
            exp_q.push_back({(n == 8) && !lf, model_digest(w, n, rounds_of(d))});
            send_frame(d, w, n, lf, 1'($urandom_range(0, 1)));
            collect(d, $urandom_range(0, 2));
        end

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
